jtag_debug_cmd_sysclk: RTL
==========================

Name: jtag_debug_cmd_sysclk

Overview:
- System-clock half of the Nios II JTAG debug path, generalised and parametrised.
- The tck-domain scan logic captures an instruction (ir_in) and a data shift register (sr), then signals vs_uir / vs_udr asynchronously.
- This block synchronises those strobes into clk, queues each completed DR scan as a command in a small FIFO, and issues it as a one-cycle take_action / take_no_action pulse indexed by IR value, together with a registered jdo.
- Adds buffering, stall back-pressure, minimum inter-command spacing and an overflow flag.

Parameters:
- IR_W, 2, instruction register width; 2**IR_W pulse lines per polarity
- SR_W, 38, shift register / jdo width
- ACT_BIT, 34, sr bit selecting take_action (1) vs take_no_action (0)
- SYNC_STAGES, 2, synchroniser flops on vs_uir/vs_udr; legal 2..4
- DEPTH, 4, command FIFO entries; power of two, >=2
- MIN_GAP, 0, idle clk cycles forced between consecutive issue pulses; legal 0..15

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ir_in  in  IR_W  instruction from tck domain; stable from vs_uir rise until the next vs_uir
- sr  in  SR_W  scan data from tck domain; stable for >= SYNC_STAGES+3 clk after vs_udr rise
- vs_uir  in  1  update-IR level from tck domain, asynchronous
- vs_udr  in  1  update-DR level from tck domain, asynchronous
- stall  in  1  CPU-side hold; 1 blocks issuing
- overflow_clr  in  1  clears overflow
- jdo  out  SR_W  data of the last issued command
- take_action  out  2**IR_W  one-hot one-cycle pulse, index = command IR
- take_no_action  out  2**IR_W  one-hot one-cycle pulse, index = command IR
- level  out  clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a command was dropped
- busy  out  1  FIFO non-empty, or state != IDLE

Behaviour:
- Reset, async assert: jdo=0, all pulses=0, level=0, overflow=0, busy=0, synchronisers=0, ir_lat=0, state=IDLE, gap counter=0. Any in-flight pulse drops immediately; FIFO contents are discarded.
- Synchronisers: each strobe passes through SYNC_STAGES flops plus one history flop. The edge is detected on the synchronised rising transition and is high for exactly one cycle per strobe rise. Falling edges are ignored.
- uir edge: ir_lat <= ir_in.
- udr edge: push {ir_lat, sr} into the FIFO.
  - If udr and uir edges land in the same cycle, the push uses the old ir_lat; ir_lat updates afterwards.
- Full handling: push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the entry is dropped and overflow <= 1.
- overflow_clr: clears overflow. If a set and a clear occur in the same cycle, set wins.
- State machine:
  - IDLE: if FIFO non-empty and stall=0, pop the head and go to ISSUE.
  - ISSUE, exactly one cycle:
    - jdo = popped sr; it changes on the IDLE->ISSUE edge and then holds.
    - take_action[ir]=1 if sr[ACT_BIT]=1, else take_no_action[ir]=1. All other lines are 0.
    - Next state: GAP if MIN_GAP>0, else IDLE.
  - GAP: count MIN_GAP cycles with pulses low, then go to IDLE. stall is ignored in GAP.
  - stall asserted during ISSUE does not cancel the pulse.
- Latency, FIFO empty and IDLE: the udr edge is detected in cycle E, the FIFO is written at the end of E, the pop happens in E+1, and the pulse is high in E+2. Minimum async-rise-to-pulse is SYNC_STAGES+3 clk edges.
- Throughput: at most one issue per 2+MIN_GAP cycles.
- level reflects pushes and pops from the previous edge; simultaneous push and pop leave it unchanged.
- Pointers wrap modulo DEPTH. Full is level==DEPTH; empty is level==0.
- At most one bit across take_action|take_no_action is ever high.

Test Plan:
- Single command: IR_W=2, uir rise with ir_in=2, then udr rise with sr=38'h4_0000_1234 (bit34=1) -> take_action[2] high exactly 1 cycle, SYNC_STAGES+3 edges after the udr rise; jdo=38'h4_0000_1234; take_no_action stays 0.
- Polarity: same sequence with sr bit34=0, ir=1 -> take_no_action[1] 1 cycle; take_action=0.
- Back-pressure/overflow: stall=1, six udr strobes with DEPTH=4 -> level=4, overflow=1, busy=1. Release stall -> 4 pulses in FIFO order, carrying the first four sr values. overflow_clr -> overflow=0.
- Spacing: MIN_GAP=3, two queued commands, stall=0 -> pulses exactly 5 cycles apart; no pulse while in GAP.
- Concurrency: uir and udr edges in the same cycle -> the command carries the old IR. Push into a full FIFO on the same cycle as a pop -> accepted, overflow stays 0.
- Reset mid-ISSUE: assert reset_n=0 during the pulse cycle -> pulses, jdo, level and busy are 0 immediately. After release, no stale command issues.

Source files
------------

// File: rtl/jtag_debug_cmd_sysclk.sv
// System-clock side of the JTAG debug command path: synchronises the tck-domain
// update strobes, queues completed DR scans and issues them as one-cycle pulses.
module jtag_debug_cmd_sysclk #(
    parameter int IR_W        = 2,
    parameter int SR_W        = 38,
    parameter int ACT_BIT     = 34,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int MIN_GAP     = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [SR_W-1:0]          sr,
    input  logic                     vs_uir,
    input  logic                     vs_udr,
    input  logic                     stall,
    input  logic                     overflow_clr,
    output logic [SR_W-1:0]          jdo,
    output logic [2**IR_W-1:0]       take_action,
    output logic [2**IR_W-1:0]       take_no_action,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     busy,
    output logic [1:0]               state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = IR_W + SR_W;
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [3:0]  GAP_LAST   = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] uir_sync, udr_sync;
    logic                   uir_hist, udr_hist;
    logic                   uir_edge, udr_edge;
    logic [IR_W-1:0]        ir_lat;

    logic [CW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic                   full, push, pop, drop;

    logic [IR_W-1:0]        cmd_ir;
    logic [3:0]             gap_cnt;

    // Strobe synchronisers; the edge flop fires once per synchronised rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync <= '0;
            udr_sync <= '0;
            uir_hist <= 1'b0;
            udr_hist <= 1'b0;
            uir_edge <= 1'b0;
            udr_edge <= 1'b0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_hist <= uir_sync[SYNC_STAGES-1];
            udr_hist <= udr_sync[SYNC_STAGES-1];
            uir_edge <= uir_sync[SYNC_STAGES-1] & ~uir_hist;
            udr_edge <= udr_sync[SYNC_STAGES-1] & ~udr_hist;
        end
    end

    // A push in the same cycle as an IR update still sees the old ir_lat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ir_lat <= '0;
        else if (uir_edge)
            ir_lat <= ir_in;
    end

    // FIFO handshake: a push (udr_edge) is accepted when the FIFO has room or a
    // pop happens on the same edge; a pop happens in IDLE when non-empty and not
    // stalled. A rejected push is dropped and flagged on overflow.
    assign full = (level == FULL_LEVEL);
    assign pop  = (state == IDLE) && (level != '0) && !stall;
    assign push = udr_edge && (!full || pop);
    assign drop = udr_edge && !push;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {ir_lat, sr};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

    // Popped command is held here; jdo only changes on the IDLE->ISSUE edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ir <= '0;
            jdo    <= '0;
        end else if (pop) begin
            {cmd_ir, jdo} <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            gap_cnt <= '0;
        else if (state == GAP)
            gap_cnt <= gap_cnt + 1'b1;
        else
            gap_cnt <= '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pop) state_next = ISSUE;
            ISSUE:   state_next = (MIN_GAP > 0) ? GAP : IDLE;
            GAP:     if (gap_cnt == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        if (state == ISSUE) begin
            if (jdo[ACT_BIT])
                take_action[cmd_ir] = 1'b1;
            else
                take_no_action[cmd_ir] = 1'b1;
        end
        busy      = (level != '0) || (state != IDLE);
        state_dbg = state;
    end

endmodule
